// File: rtl/cache_control.sv
// Cache controller for a 2-way, 8-set, 256-bit-line cache.
// Walks CPU requests through tag check, dirty writeback and line fill,
// steering the datapath muxes and array loads from the current state.
module cache_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic [1:0] hit,
  input  logic [1:0] dirty_out,
  input  logic       lru_out,
  output logic       array_read,
  output logic [1:0] load_tag,
  output logic [1:0] load_valid,
  output logic [1:0] load_dirty,
  output logic       load_lru,
  output logic       lru_in,
  output logic       line_in_mux_sel,
  output logic [1:0] line_out_mux_sel,
  output logic       dirty_in_mux_sel,
  output logic       pmem_wdata_mux_sel,
  output logic [2:0] write_en_mux_sel,
  output logic       pmem_addr_sel
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       victim_reg, victim_next;
  logic       req;
  logic       hit_way;
  logic [1:0] hit_mask;
  logic [1:0] victim_mask;

  assign req         = mem_read | mem_write;
  // way0 wins when both ways report a hit
  assign hit_way     = ~hit[0];
  assign hit_mask    = hit_way ? 2'b10 : 2'b01;
  assign victim_mask = victim_reg ? 2'b10 : 2'b01;

  // State and victim-way registers; reset drops straight back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      victim_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      victim_reg <= victim_next;
    end
  end

  // Next-state and output decode from current state and datapath inputs
  always_comb begin
    state_next         = state_reg;
    victim_next        = victim_reg;
    mem_resp           = 1'b0;
    pmem_read          = 1'b0;
    pmem_write         = 1'b0;
    array_read         = 1'b1;
    load_tag           = 2'b00;
    load_valid         = 2'b00;
    load_dirty         = 2'b00;
    load_lru           = 1'b0;
    lru_in             = 1'b0;
    line_in_mux_sel    = 1'b0;
    line_out_mux_sel   = 2'b00;
    dirty_in_mux_sel   = 1'b0;
    pmem_wdata_mux_sel = 1'b0;
    write_en_mux_sel   = 3'd0;
    pmem_addr_sel      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req) state_next = CHECK;
      end

      CHECK: begin
        if (!req) begin
          state_next = IDLE;
        end else if (|hit) begin
          mem_resp   = 1'b1;
          load_lru   = 1'b1;
          lru_in     = ~hit_way;
          state_next = IDLE;
          // a simultaneous read+write is treated as a write
          if (mem_write) begin
            write_en_mux_sel = hit_way ? 3'd6 : 3'd5;
            line_in_mux_sel  = 1'b0;
            load_dirty       = hit_mask;
            dirty_in_mux_sel = 1'b1;
          end else begin
            line_out_mux_sel = hit_mask;
          end
        end else begin
          victim_next = lru_out;
          state_next  = dirty_out[lru_out] ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write         = 1'b1;
        pmem_wdata_mux_sel = victim_reg;
        pmem_addr_sel      = 1'b1;
        if (pmem_resp) begin
          load_dirty       = victim_mask;
          dirty_in_mux_sel = 1'b0;
          state_next       = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          write_en_mux_sel = victim_reg ? 3'd2 : 3'd1;
          line_in_mux_sel  = 1'b1;
          load_tag         = victim_mask;
          load_valid       = victim_mask;
          load_dirty       = victim_mask;
          dirty_in_mux_sel = 1'b0;
          state_next       = CHECK;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 2 ways, 8 sets and 256-bit lines.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 mem_write  input  1  CPU write request, held until mem_resp.
REQ-006 mem_resp  output  1  one-cycle completion pulse to the CPU.
REQ-007 pmem_read  output  1  physical memory line read request.
REQ-008 pmem_write  output  1  physical memory line write request.
REQ-009 pmem_resp  input  1  physical memory completion pulse.
REQ-010 hit  input  2  per-way hit from the datapath.
REQ-011 dirty_out  input  2  per-way dirty bit of the indexed set.
REQ-012 lru_out  input  1  LRU way of the indexed set.
REQ-013 array_read  output  1  read strobe driven to all tag, valid, dirty, LRU and data arrays.
REQ-014 load_tag, load_valid, load_dirty  output  2 each  per-way array loads.
REQ-015 load_lru, lru_in  output  1 each  LRU load and value.
REQ-016 line_in_mux_sel  output  1  0 = CPU write data, 1 = pmem line.
REQ-017 line_out_mux_sel  output  2  01 = way0, 10 = way1, else zero.
REQ-018 dirty_in_mux_sel, pmem_wdata_mux_sel  output  1 each  dirty value written; writeback way.
REQ-019 write_en_mux_sel  output  3  1/2 = full-line write to way0/way1; 5/6 = byte-masked write to way0/way1; 0 = none.
REQ-020 pmem_addr_sel  output  1  1 = writeback address (stored tag), 0 = CPU address.

Function
REQ-021 States SHALL be IDLE, CHECK, WRITEBACK and FILL; the next state is registered and outputs are decoded from the state and inputs.
REQ-022 Defaults in every state SHALL be all outputs 0, except array_read = 1.
REQ-023 IDLE SHALL go to CHECK when mem_read or mem_write is asserted; otherwise it SHALL stay in IDLE.
REQ-024 CHECK with neither request asserted SHALL return to IDLE with no side effects.
REQ-025 CHECK hit: way w = 0 if hit[0], else 1 (way0 priority if hit = 11); SHALL assert mem_resp, load_lru = 1 and lru_in = ~w, then go to IDLE.
REQ-026 Read hit: SHALL drive line_out_mux_sel = 01 (w = 0) or 10 (w = 1).
REQ-027 Write hit: SHALL drive write_en_mux_sel = 5 + w, line_in_mux_sel = 0, load_dirty[w] = 1 and dirty_in_mux_sel = 1.
REQ-028 If mem_read and mem_write are both asserted, the access SHALL be handled as a write.
REQ-029 CHECK miss (hit = 00): the block SHALL latch victim v = lru_out into an internal register; it SHALL go to WRITEBACK if dirty_out[v] = 1, else to FILL.
REQ-030 WRITEBACK: pmem_write = 1, pmem_wdata_mux_sel = v, pmem_addr_sel = 1, held until pmem_resp.
REQ-031 On pmem_resp in WRITEBACK: load_dirty[v] = 1 with dirty_in_mux_sel = 0, then go to FILL.
REQ-032 FILL: pmem_read = 1, held until pmem_resp.
REQ-033 On pmem_resp in FILL: write_en_mux_sel = 1 + v, line_in_mux_sel = 1, load_tag[v] = load_valid[v] = load_dirty[v] = 1, dirty_in_mux_sel = 0, then go to CHECK; the re-check SHALL hit.
REQ-034 pmem_resp in IDLE or CHECK SHALL be ignored.
REQ-035 A request withdrawn during WRITEBACK or FILL SHALL NOT abort the memory transaction; the block SHALL then take the REQ-024 path.
REQ-036 mem_resp SHALL be exactly one cycle wide; pmem_read and pmem_write SHALL never be asserted together.
REQ-037 Latency: hit = mem_resp in the 2nd cycle after the request appears; clean miss = hit + fill time + 1 cycle.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, clear the victim register and drive all outputs to their defaults, including mid-WRITEBACK or mid-FILL.
REQ-039 After rst_n rises, the first request SHALL be handled from IDLE.

Verification
REQ-040 Read hit way1 (hit = 10) -> CHECK cycle: line_out_mux_sel = 10, mem_resp = 1, load_lru = 1, lru_in = 0.
REQ-041 Write hit way0 -> write_en_mux_sel = 5, load_dirty = 01, dirty_in_mux_sel = 1, mem_resp for 1 cycle.
REQ-042 Read miss, lru_out = 1, dirty_out = 00, pmem_resp after 4 cycles -> pmem_read high 4 cycles; write_en_mux_sel = 2, load_tag = load_valid = 10; re-CHECK hit; mem_resp.
REQ-043 Write miss, lru_out = 0, dirty_out = 01 -> pmem_write with pmem_wdata_mux_sel = 0 and pmem_addr_sel = 1, then FILL, then write_en_mux_sel = 5 on re-check.
REQ-044 rst_n low during FILL -> pmem_read drops in the same cycle; state is IDLE; no mem_resp.
REQ-045 Spurious pmem_resp in IDLE, then mem_read and mem_write together -> pmem_resp ignored; access treated as a write.
